// File: rtl/spi_pkg.sv
// Shared types for the multi-lane SPI receiver: FSM state, latched SPI mode
// and the mode-to-sample-edge rule.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_rx_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input spi_mode_t mode);
        return mode.cpol == mode.cpha;
    endfunction

endpackage

// File: rtl/spi_lane_shift.sv
// One serial data lane: shift register plus a right-justified, length-masked
// parallel view. The view is taken from the next-state value so the word that
// completes on this shift is available in the same cycle.
module spi_lane_shift #(
    parameter  int DATA_WIDTH = 16,
    parameter  int LSB_FIRST  = 0,
    localparam int LW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  bit_i,
    input  logic [LW-1:0]         len_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] rev;
    logic [LW-1:0]         shamt;

    // Next shift value: clear at frame start, otherwise shift the new bit in at bit 0.
    always_comb begin
        // NOTE: default assignment first so every path assigns shift_d and no latch is inferred.
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], bit_i};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    // Justify the word: the first received bit sits at len-1, so MSB-first only
    // masks stale upper bits; LSB-first reverses the register and drops the
    // (DATA_WIDTH-len) bits that were never part of this word.
    always_comb begin
        rev   = {<<{shift_d}};
        shamt = LW'(DATA_WIDTH) - len_i;
        if (LSB_FIRST != 0) begin
            word_o = rev >> shamt;
        end else begin
            word_o = shift_d & ~({DATA_WIDTH{1'b1}} << len_i);
        end
    end

endmodule

// File: rtl/spi_rx_multilane.sv
// Multi-lane SPI peripheral receiver. All SPI pins are oversampled in the clk
// domain; words are delivered on a valid/ready interface with overrun and
// abort reporting. Back-to-back words inside one CS_N assertion are supported.
module spi_rx_multilane
    import spi_pkg::*;
#(
    parameter  int DATA_WIDTH  = 16,
    parameter  int LANES       = 2,
    parameter  int SYNC_STAGES = 2,
    parameter  int LSB_FIRST   = 0,
    localparam int LW          = $clog2(DATA_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        sclk,
    input  logic                        cs_n,
    input  logic [LANES-1:0]            data_in,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic [LW-1:0]               frame_len,
    output logic [DATA_WIDTH*LANES-1:0] data_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun,
    output logic                        aborted,
    output logic                        busy
);

    localparam int             SW       = LANES + 2;
    localparam logic [SW-1:0]  SYNC_RST = {1'b1, 1'b0, {LANES{1'b0}}};

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic                           cs_s, sclk_s;
    logic [LANES-1:0]               data_s;

    spi_rx_state_t                  state_q;
    spi_mode_t                      mode_q;
    logic [LW-1:0]                  len_q, cnt_q, len_eff;
    logic                           sclk_prev_q, cs_prev_q;
    logic [DATA_WIDTH*LANES-1:0]    data_q, word_all;
    logic                           valid_q, overrun_q, aborted_q;
    logic                           sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                           start, shift_en, word_done;

    // Synchronise cs_n, sclk and the data lanes together so they keep their relative timing.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: the synchroniser resets to the idle bus (cs_n high) so no false cs_n fall is seen after reset.
            sync_q <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            // NOTE: non-blocking assignment so every stage samples its predecessor's old value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], {cs_n, sclk, data_in}};
        end
    end

    assign {cs_s, sclk_s, data_s} = sync_q[SYNC_STAGES-1];

    // Edge detection, sample-edge selection and word-completion decode.
    always_comb begin
        sclk_rise = sclk_s & ~sclk_prev_q;
        sclk_fall = ~sclk_s & sclk_prev_q;
        cs_fall   = ~cs_s & cs_prev_q;
        cs_rise   = cs_s & ~cs_prev_q;
        start     = (state_q == IDLE) && cs_fall;
        shift_en  = (state_q == ACTIVE) && !cs_rise &&
                    (sample_on_rise(mode_q) ? sclk_rise : sclk_fall);
        word_done = shift_en && ((cnt_q + LW'(1)) == len_q);
        len_eff   = ((frame_len == '0) || (frame_len > LW'(DATA_WIDTH))) ? LW'(DATA_WIDTH)
                                                                          : frame_len;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        spi_lane_shift #(
            .DATA_WIDTH (DATA_WIDTH),
            .LSB_FIRST  (LSB_FIRST)
        ) u_lane (
            .clk    (clk),
            .nrst   (nrst),
            .clr_i  (start),
            .en_i   (shift_en),
            .bit_i  (data_s[g]),
            .len_i  (len_q),
            .word_o (word_all[DATA_WIDTH*g +: DATA_WIDTH])
        );
    end

    // Frame FSM, bit counter and output handshake with registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            aborted_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q     <= ACTIVE;
                        mode_q.cpol <= cpol;
                        mode_q.cpha <= cpha;
                        len_q       <= len_eff;
                        cnt_q       <= '0;
                        overrun_q   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        if (cnt_q != '0) begin
                            aborted_q <= 1'b1;
                        end
                    end else if (shift_en) begin
                        cnt_q <= word_done ? '0 : cnt_q + LW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A completed word is taken only if the output slot is free or being freed.
            if (word_done) begin
                if (!valid_q || out_ready) begin
                    data_q  <= word_all;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign aborted   = aborted_q;
    assign busy      = ~cs_s;

endmodule

// File: tb/tb_spi_rx_multilane.sv
// Self-checking bench for spi_rx_multilane. Two instances (MSB-first and
// LSB-first) see identical pins; expected words are assembled from the
// transmitted bit list by a small reference function.
module tb_spi_rx_multilane;

    localparam int DW    = 16;
    localparam int LANES = 2;
    localparam int LW    = 5;
    localparam int HALF  = 4;

    logic                 clk, nrst, sclk, cs_n, cpol, cpha, out_ready;
    logic [LANES-1:0]     data_in;
    logic [LW-1:0]        frame_len;
    logic [DW*LANES-1:0]  data_out_m, data_out_l;
    logic                 out_valid_m, out_valid_l, overrun_m, overrun_l;
    logic                 aborted_m, aborted_l, busy_m, busy_l;

    int                   vectors, miscompares;
    int                   abort_m, abort_l;
    logic [LANES-1:0]     tx_bits [0:63];
    logic [DW*LANES-1:0]  got_m [$];
    logic [DW*LANES-1:0]  got_l [$];

    spi_rx_multilane #(.DATA_WIDTH(DW), .LANES(LANES), .SYNC_STAGES(2), .LSB_FIRST(0)) dut_m (
        .clk(clk), .nrst(nrst), .sclk(sclk), .cs_n(cs_n), .data_in(data_in),
        .cpol(cpol), .cpha(cpha), .frame_len(frame_len), .data_out(data_out_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .overrun(overrun_m),
        .aborted(aborted_m), .busy(busy_m)
    );

    spi_rx_multilane #(.DATA_WIDTH(DW), .LANES(LANES), .SYNC_STAGES(2), .LSB_FIRST(1)) dut_l (
        .clk(clk), .nrst(nrst), .sclk(sclk), .cs_n(cs_n), .data_in(data_in),
        .cpol(cpol), .cpha(cpha), .frame_len(frame_len), .data_out(data_out_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .overrun(overrun_l),
        .aborted(aborted_l), .busy(busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record accepted words and abort pulses away from the active edge.
    always @(negedge clk) begin
        if (out_valid_m && out_ready) got_m.push_back(data_out_m);
        if (out_valid_l && out_ready) got_l.push_back(data_out_l);
        if (aborted_m) abort_m++;
        if (aborted_l) abort_l++;
    end

    // Reference: build the expected word of every lane from the transmitted bits.
    function automatic logic [DW*LANES-1:0] expect_word(input int start, input int len, input bit lsb);
        logic [DW*LANES-1:0] r;
        r = '0;
        for (int ln = 0; ln < LANES; ln++)
            for (int k = 0; k < len; k++)
                if (lsb) r[DW*ln + k] = tx_bits[start+k][ln];
                else     r[DW*ln + len - 1 - k] = tx_bits[start+k][ln];
        return r;
    endfunction

    function automatic int eff_len(input int fl);
        return (fl == 0 || fl > DW) ? DW : fl;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Half SCLK period; optionally pulse out_ready in the cycle where the preceding sample edge completes.
    task automatic half_wait(input bit pulse);
        if (pulse) begin
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            tick(HALF);
        end
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) tx_bits[k] = 2'($urandom_range(0, 3));
    endtask

    task automatic fill_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input int len, input int idx, input bit lsb);
        for (int k = 0; k < len; k++)
            tx_bits[idx*len + k] = lsb ? {w1[k], w0[k]} : {w1[len-1-k], w0[len-1-k]};
    endtask

    task automatic cs_begin(input int mode, input int fl);
        cpol      = (mode >= 2);
        cpha      = ((mode % 2) == 1);
        sclk      = cpol;
        frame_len = LW'(fl);
        tick(4);
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic shift_bits(input int n, input int pulse_at);
        for (int k = 0; k < n; k++) begin
            if (!cpha) begin
                data_in = tx_bits[k];
                half_wait(1'b0);
                sclk = ~sclk;
                half_wait(k == pulse_at);
                sclk = ~sclk;
            end else begin
                sclk    = ~sclk;
                data_in = tx_bits[k];
                half_wait(1'b0);
                sclk = ~sclk;
                half_wait(k == pulse_at);
            end
        end
    endtask

    task automatic cs_end();
        tick(HALF);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic clear_obs();
        got_m.delete();
        got_l.delete();
        abort_m = 0;
        abort_l = 0;
    endtask

    task automatic test_reset();
        tick(3);
        vectors++;
        if ({data_out_m, data_out_l} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h_%h want 0", data_out_m, data_out_l);
        end
        vectors++;
        if ({out_valid_m, overrun_m, aborted_m, busy_m, out_valid_l, overrun_l, aborted_l, busy_l} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b want all 0", out_valid_m, overrun_m,
                     aborted_m, busy_m, out_valid_l, overrun_l, aborted_l, busy_l);
        end
        nrst = 1'b1;
        tick(4);
        vectors++;
        if ({out_valid_m, busy_m, out_valid_l, busy_l} !== 4'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b%b%b%b want 0000", out_valid_m, busy_m, out_valid_l, busy_l);
        end
    endtask

    task automatic test_modes();
        logic [DW*LANES-1:0] exp_m, exp_l;
        int fl, len, nw, m;
        out_ready = 1'b1;
        for (int md = 0; md < 4; md++) begin
            fill_words(16'hA5C3, 16'h1234, 16, 0, 1'b0);
            clear_obs();
            cs_begin(md, 16);
            shift_bits(16, -1);
            cs_end();
            exp_l = expect_word(0, 16, 1'b1);
            vectors++;
            if (got_m.size() != 1 || got_m[0] !== 32'h1234_A5C3) begin
                miscompares++;
                $display("FAIL mode%0d_msb: got %0d words first %h want 1 word 1234a5c3", md,
                         got_m.size(), (got_m.size() > 0) ? got_m[0] : 32'hx);
            end
            vectors++;
            if (got_l.size() != 1 || got_l[0] !== exp_l) begin
                miscompares++;
                $display("FAIL mode%0d_lsb: got %0d words first %h want 1 word %h", md,
                         got_l.size(), (got_l.size() > 0) ? got_l[0] : 32'hx, exp_l);
            end
        end
        // Random modes, frame lengths (including 0 and >DATA_WIDTH) and word counts.
        for (int it = 0; it < 6; it++) begin
            m   = int'($urandom_range(0, 3));
            fl  = int'($urandom_range(0, 31));
            nw  = int'($urandom_range(1, 3));
            len = eff_len(fl);
            fill_random(len * nw);
            clear_obs();
            cs_begin(m, fl);
            shift_bits(len * nw, -1);
            cs_end();
            vectors++;
            if (got_m.size() != nw || got_l.size() != nw || abort_m != 0 || abort_l != 0) begin
                miscompares++;
                $display("FAIL rand%0d_count: got %0d/%0d words %0d/%0d aborts want %0d words 0 aborts",
                         it, got_m.size(), got_l.size(), abort_m, abort_l, nw);
            end else begin
                for (int w = 0; w < nw; w++) begin
                    exp_m = expect_word(w*len, len, 1'b0);
                    exp_l = expect_word(w*len, len, 1'b1);
                    vectors++;
                    if (got_m[w] !== exp_m || got_l[w] !== exp_l) begin
                        miscompares++;
                        $display("FAIL rand%0d_word%0d (mode %0d len %0d): got %h/%h want %h/%h",
                                 it, w, m, fl, got_m[w], got_l[w], exp_m, exp_l);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]          w0s [3];
        logic [DW*LANES-1:0] exp_m, exp_l;
        w0s = '{5'h15, 5'h0A, 5'h1F};
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) fill_words(16'(w0s[w]), 16'(~w0s[w]), 5, w, 1'b1);
        clear_obs();
        cs_begin(0, 5);
        shift_bits(15, -1);
        cs_end();
        vectors++;
        if (got_m.size() != 3 || got_l.size() != 3 || abort_m != 0 || abort_l != 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d/%0d words %0d/%0d aborts want 3 words 0 aborts",
                     got_m.size(), got_l.size(), abort_m, abort_l);
        end else begin
            for (int w = 0; w < 3; w++) begin
                exp_l = {11'b0, ~w0s[w], 11'b0, w0s[w]};
                exp_m = expect_word(w*5, 5, 1'b0);
                vectors++;
                if (got_l[w] !== exp_l || got_m[w] !== exp_m) begin
                    miscompares++;
                    $display("FAIL b2b_word%0d: got %h/%h want %h/%h", w, got_l[w], got_m[w], exp_l, exp_m);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [DW*LANES-1:0] exp_m, exp_l;
        out_ready = 1'b0;
        fill_random(32);
        clear_obs();
        cs_begin(1, 16);
        shift_bits(32, -1);
        cs_end();
        exp_m = expect_word(0, 16, 1'b0);
        exp_l = expect_word(0, 16, 1'b1);
        vectors++;
        if ({out_valid_m, overrun_m, out_valid_l, overrun_l} !== 4'b1111) begin
            miscompares++;
            $display("FAIL overrun_flags: got valid/ovr %b%b %b%b want 11 11", out_valid_m, overrun_m,
                     out_valid_l, overrun_l);
        end
        vectors++;
        if (data_out_m !== exp_m || data_out_l !== exp_l) begin
            miscompares++;
            $display("FAIL overrun_keep_first: got %h/%h want %h/%h", data_out_m, data_out_l, exp_m, exp_l);
        end
        tick(10);
        vectors++;
        if ({overrun_m, overrun_l} !== 2'b11) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %b%b want 11", overrun_m, overrun_l);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        vectors++;
        if ({out_valid_m, out_valid_l} !== 2'b00 || data_out_m !== exp_m || data_out_l !== exp_l) begin
            miscompares++;
            $display("FAIL accept_drop_valid: got valid %b%b data %h/%h want 00 %h/%h", out_valid_m,
                     out_valid_l, data_out_m, data_out_l, exp_m, exp_l);
        end
        fill_random(16);
        clear_obs();
        out_ready = 1'b1;
        cs_begin(2, 16);
        vectors++;
        if ({overrun_m, overrun_l} !== 2'b00) begin
            miscompares++;
            $display("FAIL overrun_clear_on_cs: got %b%b want 00", overrun_m, overrun_l);
        end
        shift_bits(16, -1);
        cs_end();
        exp_m = expect_word(0, 16, 1'b0);
        exp_l = expect_word(0, 16, 1'b1);
        vectors++;
        if (got_m.size() != 1 || got_l.size() != 1 || got_m[0] !== exp_m || got_l[0] !== exp_l) begin
            miscompares++;
            $display("FAIL after_overrun_word: got %0d/%0d words want 1 word %h/%h", got_m.size(),
                     got_l.size(), exp_m, exp_l);
        end
    endtask

    task automatic test_coincide();
        logic [DW*LANES-1:0] first_m, second_m, second_l;
        out_ready = 1'b0;
        fill_random(8);
        clear_obs();
        cs_begin(0, 4);
        shift_bits(8, 7);
        cs_end();
        first_m  = expect_word(0, 4, 1'b0);
        second_m = expect_word(4, 4, 1'b0);
        second_l = expect_word(4, 4, 1'b1);
        vectors++;
        if ({out_valid_m, overrun_m, out_valid_l, overrun_l} !== 4'b1010) begin
            miscompares++;
            $display("FAIL coincide_flags: got valid/ovr %b%b %b%b want 10 10", out_valid_m, overrun_m,
                     out_valid_l, overrun_l);
        end
        vectors++;
        if (data_out_m !== second_m || data_out_l !== second_l) begin
            miscompares++;
            $display("FAIL coincide_new_word: got %h/%h want %h/%h", data_out_m, data_out_l, second_m, second_l);
        end
        vectors++;
        if (got_m.size() != 1 || got_m[0] !== first_m) begin
            miscompares++;
            $display("FAIL coincide_first_taken: got %0d words want 1 word %h", got_m.size(), first_m);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        fill_random(16);
        clear_obs();
        cs_begin(0, 16);
        vectors++;
        if ({busy_m, busy_l} !== 2'b11) begin
            miscompares++;
            $display("FAIL busy_in_frame: got %b%b want 11", busy_m, busy_l);
        end
        shift_bits(7, -1);
        cs_end();
        vectors++;
        if (abort_m != 1 || abort_l != 1) begin
            miscompares++;
            $display("FAIL abort_pulse: got %0d/%0d pulses want 1", abort_m, abort_l);
        end
        vectors++;
        if (got_m.size() != 0 || got_l.size() != 0 || {out_valid_m, out_valid_l, busy_m, busy_l} !== 4'b0) begin
            miscompares++;
            $display("FAIL abort_no_word: got %0d/%0d words valid/busy %b%b%b%b want 0 words 0000",
                     got_m.size(), got_l.size(), out_valid_m, out_valid_l, busy_m, busy_l);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW*LANES-1:0] exp_m;
        out_ready = 1'b0;
        fill_random(20);
        clear_obs();
        cs_begin(3, 16);
        shift_bits(19, -1);
        vectors++;
        if ({out_valid_m, out_valid_l} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_reset_pending: got %b%b want 11", out_valid_m, out_valid_l);
        end
        @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        vectors++;
        if ({data_out_m, data_out_l} !== '0 ||
            {out_valid_m, overrun_m, aborted_m, busy_m, out_valid_l, overrun_l, aborted_l, busy_l} !== 8'b0) begin
            miscompares++;
            $display("FAIL async_reset_mid: got data %h/%h flags %b%b%b%b %b%b%b%b want all 0", data_out_m,
                     data_out_l, out_valid_m, overrun_m, aborted_m, busy_m, out_valid_l, overrun_l,
                     aborted_l, busy_l);
        end
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick(4);
        out_ready = 1'b1;
        fill_random(16);
        clear_obs();
        cs_begin(0, 16);
        shift_bits(16, -1);
        cs_end();
        exp_m = expect_word(0, 16, 1'b0);
        vectors++;
        if (got_m.size() != 1 || got_m[0] !== exp_m || abort_m != 0) begin
            miscompares++;
            $display("FAIL after_reset_frame: got %0d words %0d aborts want 1 word %h", got_m.size(),
                     abort_m, exp_m);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        abort_m     = 0;
        abort_l     = 0;
        nrst        = 1'b0;
        sclk        = 1'b0;
        cs_n        = 1'b1;
        data_in     = '0;
        cpol        = 1'b0;
        cpha        = 1'b0;
        frame_len   = '0;
        out_ready   = 1'b0;

        test_reset();
        test_modes();
        test_back_to_back();
        test_overrun();
        test_coincide();
        test_abort();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
